// File: rtl/qpu_alu_pkg.sv
// Shared definitions for the pipelined EXU ALU: opcode encodings and adder width helper.
// The optional shifter opcodes (SLL/SRL/SRA) are only executed when QPU_ALU_SHIFT_EN is defined.
package qpu_alu_pkg;

  localparam int QPU_ALU_OPC_W = 4;

  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_ADD = 4'd0;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_SUB = 4'd1;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_XOR = 4'd2;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_OR  = 4'd3;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_AND = 4'd4;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_EQ  = 4'd5;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_NE  = 4'd6;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_LT  = 4'd7;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_GE  = 4'd8;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_LTU = 4'd9;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_GEU = 4'd10;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_SLL = 4'd11;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_SRL = 4'd12;
  localparam logic [QPU_ALU_OPC_W-1:0] QPU_ALU_OPC_SRA = 4'd13;

  // The shared adder carries one extra bit so signed and unsigned compares
  // can both be read from its top bit.
  function automatic int qpu_alu_add_w(input int xlen);
    return xlen + 1;
  endfunction

endpackage

// File: rtl/qpu_alu_rr_arb.sv
// Round-robin arbiter for the shared ALU. The pointer names the highest-priority
// channel; it moves past the granted channel only when the grant is consumed (adv).
module qpu_alu_rr_arb import qpu_alu_pkg::*; #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] valid,
  input  logic            adv,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] ptr;

  // Pick the first valid channel at or after the pointer, wrapping around.
  always_comb begin
    logic found;
    int   c;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && valid[c]) begin
        grant[c] = 1'b1;
        idx      = IDW'(c);
        found    = 1'b1;
      end
    end
  end

  // Advance the pointer to one past the winner whenever a request is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && (|valid)) begin
      ptr <= (int'(idx) == NREQ - 1) ? '0 : idx + IDW'(1);
    end
  end

endmodule

// File: rtl/qpu_exu_alu_pipe.sv
// Pipelined shared ALU for the EXU: S0 arbitrates NREQ channels, S1 registers
// the chosen operands, S2 registers the result and presents it on the rsp port.
// Optional shifter (opcodes 11..13) is built only when QPU_ALU_SHIFT_EN is defined;
// otherwise those opcodes report rsp_ill.
//
// Handshake: a request transfers on a clock edge where req_valid[i] & req_ready[i];
// a response transfers where rsp_valid & rsp_ready. rsp_* hold stable while
// rsp_valid is high and rsp_ready is low. req_ready depends on req_valid and
// downstream state only, never on itself.
module qpu_exu_alu_pipe import qpu_alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*XLEN-1:0]     req_op1,
  input  logic [NREQ*XLEN-1:0]     req_op2,
  input  logic [NREQ*QPU_ALU_OPC_W-1:0] req_opc,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_res,
  output logic                     rsp_cmp,
  output logic                     rsp_ovf,
  output logic                     rsp_ill,
  output logic [IDW-1:0]           rsp_id
);

  localparam int AW = qpu_alu_add_w(XLEN);

  logic [NREQ-1:0]          grant;
  logic [IDW-1:0]           arb_idx;
  logic                     s1_adv, s2_adv, accept;
  logic                     s1_vld;
  logic [XLEN-1:0]          s1_op1, s1_op2;
  logic [QPU_ALU_OPC_W-1:0] s1_opc;
  logic [IDW-1:0]           s1_id;

  assign s2_adv    = !rsp_valid || rsp_ready;
  assign s1_adv    = !s1_vld || s2_adv;
  assign req_ready = (rst || !s1_adv) ? '0 : grant;
  assign accept    = |(req_valid & req_ready);

  qpu_alu_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid),
    .adv   (s1_adv),
    .grant (grant),
    .idx   (arb_idx)
  );

  // S1: capture the granted channel's operands when the stage can move.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_op1 <= '0;
      s1_op2 <= '0;
      s1_opc <= '0;
      s1_id  <= '0;
    end else if (s1_adv) begin
      s1_vld <= accept;
      if (accept) begin
        s1_op1 <= req_op1[arb_idx*XLEN +: XLEN];
        s1_op2 <= req_op2[arb_idx*XLEN +: XLEN];
        s1_opc <= req_opc[arb_idx*QPU_ALU_OPC_W +: QPU_ALU_OPC_W];
        s1_id  <= arb_idx;
      end
    end
  end

  logic            is_uns, is_add, ext1, ext2, eq, ovf_raw, b_eff_msb;
  logic [AW-1:0]   a_ext, b_ext, b_eff, sum;
  logic [XLEN-1:0] nx_res;
  logic            nx_cmp, nx_ovf, nx_ill;

  // Shared adder and result select computed from the S1 registers.
  always_comb begin
    is_uns    = (s1_opc == QPU_ALU_OPC_LTU) || (s1_opc == QPU_ALU_OPC_GEU);
    is_add    = (s1_opc == QPU_ALU_OPC_ADD);
    ext1      = is_uns ? 1'b0 : s1_op1[XLEN-1];
    ext2      = is_uns ? 1'b0 : s1_op2[XLEN-1];
    a_ext     = {ext1, s1_op1};
    b_ext     = {ext2, s1_op2};
    b_eff     = is_add ? b_ext : ~b_ext;
    sum       = a_ext + b_eff + {{(AW-1){1'b0}}, ~is_add};
    b_eff_msb = b_eff[XLEN-1];
    ovf_raw   = (s1_op1[XLEN-1] == b_eff_msb) && (sum[XLEN-1] != s1_op1[XLEN-1]);
    eq        = ~|(s1_op1 ^ s1_op2);
    nx_res    = '0;
    nx_cmp    = 1'b0;
    nx_ovf    = 1'b0;
    nx_ill    = 1'b0;
    case (s1_opc)
      QPU_ALU_OPC_ADD, QPU_ALU_OPC_SUB: begin
        nx_res = sum[XLEN-1:0];
        nx_ovf = ovf_raw;
      end
      QPU_ALU_OPC_XOR: nx_res = s1_op1 ^ s1_op2;
      QPU_ALU_OPC_OR:  nx_res = s1_op1 | s1_op2;
      QPU_ALU_OPC_AND: nx_res = s1_op1 & s1_op2;
      QPU_ALU_OPC_EQ:  nx_cmp = eq;
      QPU_ALU_OPC_NE:  nx_cmp = ~eq;
      QPU_ALU_OPC_LT, QPU_ALU_OPC_LTU: nx_cmp = sum[XLEN];
      QPU_ALU_OPC_GE, QPU_ALU_OPC_GEU: nx_cmp = ~sum[XLEN];
`ifdef QPU_ALU_SHIFT_EN
      QPU_ALU_OPC_SLL: nx_res = s1_op1 << s1_op2[$clog2(XLEN)-1:0];
      QPU_ALU_OPC_SRL: nx_res = s1_op1 >> s1_op2[$clog2(XLEN)-1:0];
      QPU_ALU_OPC_SRA: nx_res = XLEN'($signed(s1_op1) >>> s1_op2[$clog2(XLEN)-1:0]);
`endif
      default: nx_ill = 1'b1;
    endcase
  end

  // S2: result register doubles as the response port; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_cmp   <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_ill   <= 1'b0;
      rsp_id    <= '0;
    end else if (s2_adv) begin
      rsp_valid <= s1_vld;
      if (s1_vld) begin
        rsp_res <= nx_res;
        rsp_cmp <= nx_cmp;
        rsp_ovf <= nx_ovf;
        rsp_ill <= nx_ill;
        rsp_id  <= s1_id;
      end
    end
  end

endmodule
